// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port memory arbiter.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int MEM_DEPTH_DEF = 12;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_RESP   = ST_RESP
  } state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker. Policy set by MEM_ARB_ROUND_ROBIN_EN:
// defined = round-robin on ties against last_grant, undefined = port 0 priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic p0_req_i,
  input  logic p1_req_i,
  input  logic last_grant_i,
  output logic grant_id_o,
  output logic grant_valid_o
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    grant_valid_o = p0_req_i | p1_req_i;
    grant_id_o    = PORT0;
    if (p0_req_i && p1_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_id_o = ~last_grant_i;
`else
      grant_id_o = PORT0;
`endif
    end else if (p1_req_i) begin
      grant_id_o = PORT1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the shared word memory (IDLE -> ACCESS -> RESP).
// Tie policy selected in mem_arb_pick by MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [ADDR_W:0] DEPTH = MEM_DEPTH[ADDR_W:0];

  state_e            state_q;
  logic              gnt_id_q, we_q, ok_q, mem_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_in_q;
  logic              p0_ack_q, p1_ack_q, p0_err_q, p1_err_q;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;
  logic              last_grant_q;

  logic              grant_id, grant_valid;
  logic              sel_we_d, sel_ok_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d, rdata_d;

  mem_arb_pick u_pick (
    .p0_req_i      (p0_req),
    .p1_req_i      (p1_req),
    .last_grant_i  (last_grant_q),
    .grant_id_o    (grant_id),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    sel_we_d    = (grant_id == PORT1) ? p1_we    : p0_we;
    sel_addr_d  = (grant_id == PORT1) ? p1_addr  : p0_addr;
    sel_wdata_d = (grant_id == PORT1) ? p1_wdata : p0_wdata;
    sel_ok_d    = ({1'b0, sel_addr_d} < DEPTH);
    rdata_d     = (!we_q && ok_q) ? mem_out : '0;
  end

  // last_grant_q is only read by the round-robin picker; fixed priority leaves it dead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      gnt_id_q     <= PORT0;
      we_q         <= 1'b0;
      ok_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_in_q     <= '0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_err_q     <= 1'b0;
      p1_err_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      last_grant_q <= PORT1;
    end else begin
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_valid) begin
            gnt_id_q     <= grant_id;
            we_q         <= sel_we_d;
            ok_q         <= sel_ok_d;
            mem_addr_q   <= sel_addr_d;
            mem_in_q     <= sel_wdata_d;
            mem_en_q     <= sel_we_d & sel_ok_d;
            last_grant_q <= grant_id;
            state_q      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          mem_en_q <= 1'b0;
          if (gnt_id_q == PORT1) begin
            p1_ack_q   <= 1'b1;
            p1_rdata_q <= rdata_d;
            p1_err_q   <= ~ok_q;
          end else begin
            p0_ack_q   <= 1'b1;
            p0_rdata_q <= rdata_d;
            p0_err_q   <= ~ok_q;
          end
          state_q <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;
  assign mem_in   = mem_in_q;
  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign p0_err   = p0_err_q;
  assign p1_err   = p1_err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the shared 16-bit word memory (`mem`), placed between the instruction-fetch port (port 0) and the load/store port (port 1). Each port issues a single read or write via a req/ack handshake. The arbiter grants one port and drives the memory's `en`/`addr`/`in` pins. It returns read data, or an out-of-range error, with a one-cycle `ack` pulse.

## Interface
- `DATA_W`, 16, data word width
- `ADDR_W`, 16, address width
- `MEM_DEPTH`, 12, number of valid words; addresses `>= MEM_DEPTH` are out of range

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `p0_req` / `p1_req`  in  1  request; held high with fields stable until `ack`
- `p0_we` / `p1_we`  in  1  1 = write, 0 = read
- `p0_addr` / `p1_addr`  in  ADDR_W  word address
- `p0_wdata` / `p1_wdata`  in  DATA_W  write data
- `p0_ack` / `p1_ack`  out  1  one-cycle completion pulse
- `p0_rdata` / `p1_rdata`  out  DATA_W  read data; valid with `ack`, held until next `ack` on that port
- `p0_err` / `p1_err`  out  1  out-of-range flag; valid with `ack`
- `mem_en`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_in`  out  DATA_W  memory write data
- `mem_out`  in  DATA_W  memory combinational read data

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- **IDLE:**
  - If any `req` is high, pick a winner (see Configuration).
  - Latch the winner's id, `we`, `addr`, `wdata`, and `range_ok = (addr < MEM_DEPTH)`.
  - Go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS:**
  - `mem_addr` and `mem_in` = latched values.
  - `mem_en = we & range_ok`; the memory commits the write on the edge leaving ACCESS.
  - On that edge, register `rdata = (!we & range_ok) ? mem_out : 0` and `err = !range_ok`.
  - Go to RESP.
- **RESP:**
  - Assert `ack` of the granted port for exactly one cycle. Update that port's `rdata`/`err`; the other port's outputs are unchanged.
  - Go to IDLE.
- A requester must drop `req` in the cycle after `ack`. If `req` is still high in IDLE, it is a new request.
- A write also returns `rdata = 0`.
- An out-of-range access never asserts `mem_en`.
- Only the granted port is serviced. The loser keeps `req` high and is reconsidered on the next return to IDLE.

## Timing
- Request sampled in IDLE at edge N. `mem_en`/`mem_addr` are valid during cycle N+1. `ack` is high during cycle N+2. Latency is 2 cycles from the sampling edge.
- Peak throughput is 1 access per 3 cycles.
- All outputs come from registers or the latched state; there are no combinational paths from `req` to outputs.
- **Reset values:** state = IDLE, `mem_en`/`mem_addr`/`mem_in` = 0, both `ack` = 0, both `rdata` = 0, both `err` = 0, `last_grant` = 1 (so port 0 wins the first tie).
- **Reset mid-operation:** asserting `rst` during ACCESS forces IDLE asynchronously and drops `mem_en` immediately, so no write is committed. A pending `ack` is discarded. Requesters must re-issue.
- **Simultaneous requests in IDLE:** arbitration policy decides; exactly one grant per transaction.
- **Address wrap:** none. Addresses `12..0xFFFF` return `err`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - The winner on a tie is the port not equal to `last_grant`.
  - `last_grant` updates on every grant.
  - Without a tie, the sole requester wins.
- Macro undefined:
  - Fixed priority; port 0 always wins ties.
  - `last_grant` register is removed.

## Structure
- Shared package `mem_arb_pkg` holds:
  - State encoding constants: `ST_IDLE=2'd0`, `ST_ACCESS=2'd1`, `ST_RESP=2'd2`.
  - Default `MEM_DEPTH`.
  - Port id constants `PORT0`/`PORT1`.
- One sub-module, `mem_arb_pick`: a 2-way picker taking both `req`s and `last_grant`, returning `grant_id` and `grant_valid`. The policy macro is confined to it.
- FSM, latches, and response registers live in `mem_arbiter`.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles. All outputs are 0 and the state is IDLE. Release, with `mem` pre-loaded (word 3 = 0x1234).
- **Port 0 read:** `addr` = 3. `p0_ack` is high 2 cycles after sampling, with `p0_rdata` = 0x1234 and `p0_err` = 0. `mem_en` is never high.
- **Port 1 write:** `addr` = 5, `wdata` = 0xBEEF. `mem_en` is high for exactly one cycle with `mem_addr` = 5. A subsequent port 0 read of 5 returns 0xBEEF.
- **Both ports request reads continuously:**
  - With `MEM_ARB_ROUND_ROBIN_EN`: `ack` order is p0, p1, p0, p1.
  - Without it: only p0 acks while p0 keeps re-requesting.
- **Out-of-range write:** `addr` = 12, `wdata` = 0xFFFF. `p0_err` = 1 and `p0_rdata` = 0 with `ack`. `mem_en` stays 0 and memory contents are unchanged.
- **Reset mid-write:** pull `rst` low during ACCESS of a write to `addr` 2, `wdata` 0xAAAA. `mem_en` drops immediately, no `ack` is issued, and word 2 keeps its old value.
